// File: rtl/sys_bus_mem_responder_pkg.sv
// sys_bus_mem_responder_pkg: shared response codes, bus width and FSM state encoding
package sys_bus_mem_responder_pkg;
    localparam int          DATA_W      = 32;
    localparam logic [31:0] RESP_OKAY   = 32'h0;
    localparam logic [31:0] RESP_SLVERR = 32'h1;
    typedef enum logic [2:0] {
        IDLE, RD_MEM, RD_CAP, WR_MEM, WAIT, RD_RESP, WR_RESP
    } state_t;
endpackage

// File: rtl/sys_bus_mem_responder_timer.sv
// bus_resp_timer: 8-bit loadable down-counter; done flags the last wait cycle
module bus_resp_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_val,
    input  logic       i_dec,
    output logic       o_done
);
    logic [7:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= 8'd0;
        else if (i_load) r_cnt <= i_val;
        else if (i_dec && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
    end
    assign o_done = r_cnt == 8'd1;
endmodule

// File: rtl/sys_bus_mem_responder.sv
// sys_bus_mem_responder: system-bus slave serving one transaction at a time from a
// single-port synchronous SRAM, with optional response delay
module sys_bus_mem_responder
    import sys_bus_mem_responder_pkg::*;
#(
    parameter int         MEM_AW     = 14,
    parameter logic [7:0] RESP_DELAY = 8'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                readAddr_valid,
    input  logic [DATA_W-1:0]   readAddr,
    output logic                readAddr_ready,
    output logic                readData_valid,
    input  logic                readData_ready,
    output logic [DATA_W-1:0]   readData,
    input  logic                writeAddr_valid,
    input  logic [DATA_W-1:0]   writeAddr,
    output logic                writeAddr_ready,
    input  logic                writeData_valid,
    input  logic [DATA_W-1:0]   writeData,
    input  logic [3:0]          writeStrb,
    output logic                writeData_ready,
    output logic                writeResp_valid,
    input  logic                writeResp_ready,
    output logic [DATA_W-1:0]   writeResp_msg,
    output logic                mem_en,
    output logic [3:0]          mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    state_t              r_state, w_next;
    logic [MEM_AW-1:0]   r_addr;
    logic                r_oob, r_is_read;
    logic [DATA_W-1:0]   r_wdata, r_rdata, r_resp;
    logic [3:0]          r_strb;
    logic                w_idle, w_wpair, w_accept, w_access;
    logic                w_load, w_dec, w_done;
    logic [DATA_W-1:0]   w_req_addr;

    assign w_idle     = r_state == IDLE;
    assign w_wpair    = writeAddr_valid & writeData_valid;
    assign w_accept   = w_idle & (w_wpair | readAddr_valid);
    assign w_req_addr = w_wpair ? writeAddr : readAddr;

    // A write needs both address and data present; it takes priority over a read.
    assign writeAddr_ready = w_idle & w_wpair;
    assign writeData_ready = w_idle & w_wpair;
    assign readAddr_ready  = w_idle & readAddr_valid & ~w_wpair;
    assign readData_valid  = r_state == RD_RESP;
    assign writeResp_valid = r_state == WR_RESP;
    assign readData        = r_rdata;
    assign writeResp_msg   = r_resp;

    assign w_access  = (r_state == RD_MEM || r_state == WR_MEM) && !r_oob;
    assign mem_en    = w_access;
    assign mem_we    = (r_state == WR_MEM && !r_oob) ? r_strb : 4'd0;
    assign mem_addr  = w_access ? r_addr : '0;
    assign mem_wdata = r_state == WR_MEM ? r_wdata : '0;

    bus_resp_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (RESP_DELAY),
        .i_dec  (w_dec),
        .o_done (w_done)
    );

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            IDLE:    w_next = w_wpair ? WR_MEM : readAddr_valid ? RD_MEM : IDLE;
            RD_MEM:  w_next = RD_CAP;
            RD_CAP, WR_MEM: begin
                w_load = 1'b1;
                w_next = RESP_DELAY != 8'd0 ? WAIT : r_state == RD_CAP ? RD_RESP : WR_RESP;
            end
            WAIT: begin
                w_dec  = 1'b1;
                w_next = w_done ? (r_is_read ? RD_RESP : WR_RESP) : WAIT;
            end
            RD_RESP: w_next = readData_ready ? IDLE : RD_RESP;
            WR_RESP: w_next = writeResp_ready ? IDLE : WR_RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_oob     <= 1'b0;
            r_is_read <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= 4'd0;
            r_rdata   <= '0;
            r_resp    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr    <= w_req_addr[MEM_AW+1:2];
                r_oob     <= (w_req_addr >> (MEM_AW + 2)) != '0;
                r_is_read <= ~w_wpair;
                r_wdata   <= writeData;
                r_strb    <= writeStrb;
            end
            if (r_state == RD_CAP) r_rdata <= r_oob ? '0 : mem_rdata;
            if (r_state == WR_MEM) r_resp <= r_oob ? RESP_SLVERR : RESP_OKAY;
        end
    end
endmodule

// File: tb/tb_sys_bus_mem_responder.sv
// tb_sys_bus_mem_responder: transaction-level model plus directed vectors for the responder
module tb_sys_bus_mem_responder;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          readAddr_valid = 0, readData_ready = 0, writeAddr_valid = 0;
    logic          writeData_valid = 0, writeResp_ready = 0;
    logic [31:0]   readAddr = 0, writeAddr = 0, writeData = 0;
    logic [3:0]    writeStrb = 0;
    logic          readAddr_ready, readData_valid, writeAddr_ready, writeData_ready;
    logic          writeResp_valid, mem_en;
    logic [31:0]   readData, writeResp_msg, mem_wdata, mem_rdata;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;

    logic          readAddr_valid4 = 0, readData_ready4 = 0;
    logic [31:0]   readAddr4 = 0;
    logic          readAddr_ready4, readData_valid4, writeAddr_ready4, writeData_ready4;
    logic          writeResp_valid4, mem_en4;
    logic [31:0]   readData4, writeResp_msg4, mem_wdata4, mem_rdata4;
    logic [3:0]    mem_we4;
    logic [AW-1:0] mem_addr4;

    sys_bus_mem_responder #(.MEM_AW(AW), .RESP_DELAY(8'd0)) dut (
        .clk(clk), .rst(rst),
        .readAddr_valid(readAddr_valid), .readAddr(readAddr), .readAddr_ready(readAddr_ready),
        .readData_valid(readData_valid), .readData_ready(readData_ready), .readData(readData),
        .writeAddr_valid(writeAddr_valid), .writeAddr(writeAddr), .writeAddr_ready(writeAddr_ready),
        .writeData_valid(writeData_valid), .writeData(writeData), .writeStrb(writeStrb),
        .writeData_ready(writeData_ready), .writeResp_valid(writeResp_valid),
        .writeResp_ready(writeResp_ready), .writeResp_msg(writeResp_msg),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    sys_bus_mem_responder #(.MEM_AW(AW), .RESP_DELAY(8'd4)) dut4 (
        .clk(clk), .rst(rst),
        .readAddr_valid(readAddr_valid4), .readAddr(readAddr4), .readAddr_ready(readAddr_ready4),
        .readData_valid(readData_valid4), .readData_ready(readData_ready4), .readData(readData4),
        .writeAddr_valid(1'b0), .writeAddr(32'h0), .writeAddr_ready(writeAddr_ready4),
        .writeData_valid(1'b0), .writeData(32'h0), .writeStrb(4'h0),
        .writeData_ready(writeData_ready4), .writeResp_valid(writeResp_valid4),
        .writeResp_ready(1'b0), .writeResp_msg(writeResp_msg4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata4)
    );

    // Environment SRAMs: a real byte-writable array for dut, an address pattern for dut4.
    bit [31:0] sram [2**AW];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'd0) mem_rdata <= sram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    always @(posedge clk) if (mem_en4) mem_rdata4 <= 32'hC0DE_0000 | 32'(mem_addr4);

    int n_checks = 0, n_errors = 0;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding request, fixed latencies, reference memory.
    bit [31:0]   ref_mem [2**AW];
    int          cyc = 0, m_acc = 0;
    bit          m_busy = 0, m_is_rd = 0, m_oob = 0;
    bit [AW-1:0] m_word;
    bit [31:0]   m_rdata, m_resp, m_wdata;
    bit [3:0]    m_strb;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) m_busy = 0;
        else if (m_busy) begin
            if (cyc >= m_acc + (m_is_rd ? 2 : 1) && (m_is_rd ? readData_ready : writeResp_ready))
                m_busy = 0;
            cyc++;
        end else begin
            cyc++;
            if (writeAddr_valid && writeData_valid) begin
                m_is_rd = 0;
                m_oob   = (writeAddr >> (AW + 2)) != 0;
                m_word  = writeAddr[AW+1:2];
                m_wdata = writeData;
                m_strb  = writeStrb;
                m_resp  = m_oob ? 32'h1 : 32'h0;
                if (!m_oob)
                    for (int b = 0; b < 4; b++)
                        if (m_strb[b]) ref_mem[m_word][8*b +: 8] = m_wdata[8*b +: 8];
                m_acc = cyc; m_busy = 1;
            end else if (readAddr_valid) begin
                m_is_rd = 1;
                m_oob   = (readAddr >> (AW + 2)) != 0;
                m_word  = readAddr[AW+1:2];
                m_rdata = m_oob ? 32'h0 : ref_mem[m_word];
                m_acc = cyc; m_busy = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            bit wpair, due, e_en;
            wpair = writeAddr_valid && writeData_valid;
            due   = m_busy && cyc >= m_acc + (m_is_rd ? 2 : 1);
            e_en  = m_busy && cyc == m_acc && !m_oob;
            chk("wa_ready", writeAddr_ready, !m_busy && wpair);
            chk("wd_ready", writeData_ready, !m_busy && wpair);
            chk("ra_ready", readAddr_ready, !m_busy && readAddr_valid && !wpair);
            chk("rd_valid", readData_valid, due && m_is_rd);
            chk("wr_valid", writeResp_valid, due && !m_is_rd);
            if (due && m_is_rd) chk("rd_data", readData, m_rdata);
            if (due && !m_is_rd) chk("wr_msg", writeResp_msg, m_resp);
            chk("mem_en", mem_en, e_en);
            if (e_en) begin
                chk("mem_addr", mem_addr, m_word);
                chk("mem_we", mem_we, m_is_rd ? 4'd0 : m_strb);
                if (!m_is_rd) chk("mem_wdata", mem_wdata, m_wdata);
            end
        end
    end

    task automatic wait_accept();
        int t = 0;
        do begin @(posedge clk); #1; t++; end while (!m_busy && t < 30);
        if (!m_busy) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout at %0t", $time);
        end
        if (m_is_rd) readAddr_valid = 0;
        else begin writeAddr_valid = 0; writeData_valid = 0; end
    endtask

    task automatic wait_due();
        int t = 0;
        do begin @(negedge clk); t++; end
        while (!(m_busy && cyc >= m_acc + (m_is_rd ? 2 : 1)) && t < 30);
        if (t >= 30) begin
            n_checks++; n_errors++;
            $display("FAIL resp_timeout at %0t", $time);
        end
    endtask

    task automatic complete(input int lag, input logic [31:0] exp, input string nm);
        wait_due();
        repeat (lag) @(negedge clk);
        chk({nm, "_model"}, m_is_rd ? m_rdata : m_resp, exp);
        chk(nm, m_is_rd ? readData : writeResp_msg, exp);
        if (m_is_rd) readData_ready = 1; else writeResp_ready = 1;
        @(posedge clk); #1;
        readData_ready = 0; writeResp_ready = 0;
    endtask

    task automatic wr(input logic [31:0] a, d, input logic [3:0] s, input logic [31:0] e, input string nm);
        writeAddr = a; writeData = d; writeStrb = s;
        writeAddr_valid = 1; writeData_valid = 1;
        wait_accept();
        complete(0, e, nm);
    endtask

    task automatic rd(input logic [31:0] a, input int lag, input logic [31:0] e, input string nm);
        readAddr = a; readAddr_valid = 1;
        wait_accept();
        complete(lag, e, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rdata", readData, 0);
        chk("rst_rvalid", readData_valid, 0);
        chk("rst_wvalid", writeResp_valid, 0);
        chk("rst_msg", writeResp_msg, 0);
        chk("rst_mem", {mem_en, mem_we, 18'(mem_addr)}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata4", readData4, 0);
        rst = 0;
        @(posedge clk); #1;

        wr(32'h10, 32'hA5A5_1234, 4'hF, 32'h0, "wr_full");
        rd(32'h10, 0, 32'hA5A5_1234, "rd_full");
        wr(32'h10, 32'h0000_BB00, 4'b0010, 32'h0, "wr_byte1");
        rd(32'h10, 2, 32'hA5A5_BB34, "rd_merged");

        readAddr = 32'h10; readAddr_valid = 1;
        writeAddr = 32'h20; writeData = 32'h1111_2222; writeStrb = 4'hF;
        writeAddr_valid = 1; writeData_valid = 1;
        @(negedge clk);
        chk("both_wa_ready", writeAddr_ready, 1);
        chk("both_ra_ready", readAddr_ready, 0);
        wait_accept();
        complete(0, 32'h0, "both_wr");
        wait_accept();
        complete(0, 32'hA5A5_BB34, "both_rd");

        writeAddr = 32'h30; writeAddr_valid = 1;
        repeat (3) @(negedge clk);
        chk("lone_wa", writeAddr_ready, 0);
        writeAddr_valid = 0; writeData_valid = 1;
        repeat (3) @(negedge clk);
        chk("lone_wd", writeData_ready, 0);
        writeData_valid = 0;
        @(posedge clk); #1;

        wr(32'h1 << (AW + 2), 32'hDEAD_BEEF, 4'hF, 32'h1, "wr_oob");
        rd(32'h1 << (AW + 2), 0, 32'h0, "rd_oob");
        rd(32'h0, 0, 32'h0, "rd_alias0");
        wr(32'h20, 32'hFFFF_FFFF, 4'h0, 32'h0, "wr_strb0");
        rd(32'h20, 0, 32'h1111_2222, "rd_strb0");

        readAddr = 32'h20; readAddr_valid = 1;
        wait_accept();
        wait_due();
        chk("pre_rst_valid", readData_valid, 1);
        #2 rst = 1;
        #1;
        chk("mid_rst_valid", readData_valid, 0);
        chk("mid_rst_data", readData, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        rd(32'h10, 0, 32'hA5A5_BB34, "rd_after_rst");

        wr(32'h40, 32'h0BAD_CAFE, 4'b1100, 32'h0, "wr_b2b");
        rd(32'h40, 0, 32'h0BAD_0000, "rd_b2b");

        readAddr4 = 32'h14; readAddr_valid4 = 1;
        @(negedge clk);
        chk("d4_ra_ready", readAddr_ready4, 1);
        @(posedge clk); #1;
        readAddr_valid4 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("d4_valid_c%0d", k), readData_valid4, k >= 7);
            if (k >= 7) chk($sformatf("d4_data_c%0d", k), readData4, 32'hC0DE_0005);
            if (k == 10) readData_ready4 = 1;
        end
        @(negedge clk);
        readData_ready4 = 0;
        chk("d4_valid_done", readData_valid4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
